// File: rtl/t_using_jk_pkg.sv
// -----------------------------------------------------------------------------
// t_using_jk_pkg
// Shared definitions for the T flip-flop built on a JK flip-flop.
//   - JK mode encodings, indexed as {J,K}
//   - Reset value of the stored state
//   - jk_next(): next-state function of a single JK bit
// -----------------------------------------------------------------------------
package t_using_jk_pkg;

    // JK mode encodings, indexed as {J,K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Value q takes on reset; qb follows as its complement
    localparam logic RESET_Q = 1'b0;

    // Next state of one JK bit given its {J,K} pair and current state
    function automatic logic jk_next(input logic [1:0] jk, input logic q_cur);
        logic res;
        res = q_cur;
        case (jk)
            JK_HOLD: res = q_cur;
            JK_RST:  res = 1'b0;
            JK_SET:  res = 1'b1;
            JK_TOG:  res = ~q_cur;
            default: res = q_cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/t_using_jk_if.sv
// -----------------------------------------------------------------------------
// t_using_jk_if
// Bundle of the data signals around a WIDTH-bit T flip-flop.
//   t  : toggle enable per bit (driven by master)
//   q  : registered state      (driven by slave)
//   qb : complement of q       (driven by slave)
// Clock and reset are kept outside the bundle as plain ports.
// -----------------------------------------------------------------------------
interface t_using_jk_if #(
    parameter int WIDTH = 1
) ();

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;

    // Side that drives the toggle enables and observes the state
    modport master (
        output t,
        input  q,
        input  qb
    );

    // Side that holds the state (the flip-flop itself)
    modport slave (
        input  t,
        output q,
        output qb
    );

endinterface

// File: rtl/t_using_jk_jk_ff.sv
// -----------------------------------------------------------------------------
// jk_ff
// WIDTH-bit JK flip-flop, each bit independent.
// Ports:
//   clk : clock, state updates on rising edge
//   rst : synchronous active-high reset, forces q=0 / qb=1
//   j,k : per-bit JK controls (hold / reset / set / toggle)
//   q   : registered state
//   qb  : complement of q, taken from the same register
// -----------------------------------------------------------------------------
module jk_ff
    import t_using_jk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    // Per-bit next-state; no interaction between bits
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign q_next[gi] = jk_next({j[gi], k[gi]}, q_reg[gi]);
        end
    endgenerate

    // Reset wins over any JK mode in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= {WIDTH{RESET_Q}};
        end else begin
            q_reg <= q_next;
        end
    end

    // qb is derived from q_reg so the pair can never disagree
    assign q  = q_reg;
    assign qb = ~q_reg;

endmodule

// File: rtl/t_using_jk.sv
// -----------------------------------------------------------------------------
// t_using_jk
// WIDTH-bit T flip-flop: J and K of an internal JK flip-flop are both tied to
// t, so each bit holds when t=0 and toggles when t=1. Holding t=1 gives a
// divide-by-2 of clk.
// Ports (positional order is fixed for existing instantiations):
//   t   : toggle enable per bit
//   clk : clock, state updates on rising edge
//   rst : synchronous active-high reset, forces q=0 / qb=1
//   q   : registered state
//   qb  : complement of q
// -----------------------------------------------------------------------------
module t_using_jk #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] t,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // With J=K=t only the hold and toggle modes of the JK are reachable
    jk_ff #(
        .WIDTH (WIDTH)
    ) u_jk_ff (
        .clk (clk),
        .rst (rst),
        .j   (t),
        .k   (t),
        .q   (q),
        .qb  (qb)
    );

endmodule

// File: tb/tb_t_using_jk.sv
// -----------------------------------------------------------------------------
// tb_t_using_jk
// Directed testbench for t_using_jk: a scalar instance and a 4-bit instance.
// Inputs change on falling edges; outputs are sampled away from rising edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_t_using_jk;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    t_using_jk_if #(.WIDTH(1)) bif ();
    t_using_jk_if #(.WIDTH(4)) wif ();

    t_using_jk #(.WIDTH(1)) dut (
        .t   (bif.t),
        .clk (clk),
        .rst (rst),
        .q   (bif.q),
        .qb  (bif.qb)
    );

    t_using_jk #(.WIDTH(4)) dut4 (
        .t   (wif.t),
        .clk (clk),
        .rst (rst),
        .q   (wif.q),
        .qb  (wif.qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound in case anything stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reset from time 0, checked after the edge at 5 (sampled at 10)
    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (bif.q !== 1'b0 || bif.qb !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: q=%b qb=%b, required q=0 qb=1", bif.q, bif.qb);
        end
        vectors++;
        if (wif.q !== 4'b0000 || wif.qb !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_w4: q=%b qb=%b, required q=0000 qb=1111", wif.q, wif.qb);
        end
        $display("reset: q=%b qb=%b q4=%b qb4=%b", bif.q, bif.qb, wif.q, wif.qb);
        rst = 1'b0;
        bif.t = 1'b0;
    endtask

    // rst=0, t=0 from 10; after edge at 15 q stays 0
    task automatic test_hold();
        @(negedge clk);
        vectors++;
        if (bif.q !== 1'b0 || bif.qb !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_after_reset: q=%b qb=%b, required q=0 qb=1", bif.q, bif.qb);
        end
        $display("hold: q=%b qb=%b", bif.q, bif.qb);
        bif.t = 1'b1;
    endtask

    // t=1 from 20 -> q=1 after 25; t=0 from 30 -> q held after 35
    task automatic test_toggle();
        @(negedge clk);
        vectors++;
        if (bif.q !== 1'b1 || bif.qb !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle: q=%b qb=%b, required q=1 qb=0", bif.q, bif.qb);
        end
        $display("toggle: q=%b qb=%b", bif.q, bif.qb);
        bif.t = 1'b0;
        @(negedge clk);
        vectors++;
        if (bif.q !== 1'b1 || bif.qb !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_hold: q=%b qb=%b, required q=1 qb=0", bif.q, bif.qb);
        end
        $display("toggle_hold: q=%b qb=%b", bif.q, bif.qb);
        bif.t = 1'b1;
    endtask

    // t=1 from 40 to 60: q=0 after 45, q=1 after 55; t=0 after -> held
    task automatic test_back_to_back();
        logic exp_q [4];
        exp_q[0] = 1'b0;
        exp_q[1] = 1'b1;
        exp_q[2] = 1'b1;
        exp_q[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bif.q !== exp_q[i] || bif.qb !== ~exp_q[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: q=%b qb=%b, required q=%b qb=%b",
                         i, bif.q, bif.qb, exp_q[i], ~exp_q[i]);
            end
            $display("back_to_back[%0d]: q=%b qb=%b", i, bif.q, bif.qb);
            if (i == 1) bif.t = 1'b0;
        end
    endtask

    // q=1, rst and t both asserted mid-cycle: no async change, then reset wins
    task automatic test_reset_priority();
        rst   = 1'b1;
        bif.t = 1'b1;
        #2;
        vectors++;
        if (bif.q !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_no_async: q=%b, required q=1", bif.q);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bif.q !== 1'b0 || bif.qb !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_priority: q=%b qb=%b, required q=0 qb=1", bif.q, bif.qb);
        end
        $display("reset_priority: q=%b qb=%b", bif.q, bif.qb);
        @(negedge clk);
        // Release reset with t=1 mid-cycle: still no change until the edge
        rst = 1'b0;
        #2;
        vectors++;
        if (bif.q !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release_no_async: q=%b, required q=0", bif.q);
        end
    endtask

    // First edge with rst=0 toggles from q=0
    task automatic test_deassert();
        @(posedge clk);
        #1;
        vectors++;
        if (bif.q !== 1'b1 || bif.qb !== 1'b0) begin
            miscompares++;
            $display("FAIL deassert_toggle: q=%b qb=%b, required q=1 qb=0", bif.q, bif.qb);
        end
        $display("deassert: q=%b qb=%b", bif.q, bif.qb);
        @(negedge clk);
        rst   = 1'b1;
        bif.t = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        vectors++;
        if (bif.q !== 1'b0) begin
            miscompares++;
            $display("FAIL re_reset: q=%b, required q=0", bif.q);
        end
    endtask

    // t=1 for 8 cycles from q=0: 1,0,1,0,1,0,1,0
    task automatic test_continuous();
        logic exp_q;
        bif.t = 1'b1;
        exp_q = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_q = ~exp_q;
            vectors++;
            if (bif.q !== exp_q || bif.qb !== ~exp_q) begin
                miscompares++;
                $display("FAIL continuous[%0d]: q=%b qb=%b, required q=%b qb=%b",
                         i, bif.q, bif.qb, exp_q, ~exp_q);
            end
            $display("continuous[%0d]: q=%b qb=%b", i, bif.q, bif.qb);
        end
        bif.t = 1'b0;
    endtask

    // 4-bit instance: bits toggle independently, no carry
    task automatic test_width();
        logic [3:0] t_vec [4];
        logic [3:0] exp_vec [4];
        t_vec[0] = 4'b0101; exp_vec[0] = 4'b0101;
        t_vec[1] = 4'b0011; exp_vec[1] = 4'b0110;
        t_vec[2] = 4'b1000; exp_vec[2] = 4'b1110;
        t_vec[3] = 4'b1111; exp_vec[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            wif.t = t_vec[i];
            @(negedge clk);
            vectors++;
            if (wif.q !== exp_vec[i] || wif.qb !== ~exp_vec[i]) begin
                miscompares++;
                $display("FAIL width4[%0d]: t=%b q=%b qb=%b, required q=%b qb=%b",
                         i, t_vec[i], wif.q, wif.qb, exp_vec[i], ~exp_vec[i]);
            end
            $display("width4[%0d]: t=%b q=%b qb=%b", i, t_vec[i], wif.q, wif.qb);
        end
        wif.t = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        bif.t = 1'b0;
        wif.t = 4'b0000;

        test_reset();
        test_hold();
        test_toggle();
        test_back_to_back();
        test_reset_priority();
        test_deassert();
        test_continuous();
        test_width();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
